// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, the blank
// segment pattern and the active-low hex glyph table.
package seg_pkg;

   localparam int         DIGITS    = 4;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef logic [1:0] digit_idx_t;

   // Active-low {g,f,e,d,c,b,a}; the entry for code 0 sits in the low bits.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
      return HEX_SEG[nibble];
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = hex_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode display scanner: one digit per rising edge of
// div_clock, double-buffered display data committed at the frame boundary.
module seven_seg_scanner #(
   parameter int DIGITS        = 4,
   parameter int BLANK_LEADING = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        div_clock,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic        load,
   output logic        busy,
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic        frame_done
);
   import seg_pkg::*;

   logic        s1_q, s2_q, s3_q;
   logic        scan_tick;
   digit_idx_t  digit_idx_q;
   logic [15:0] disp_value_q, pend_value_q;
   logic [3:0]  disp_dp_q, pend_dp_q;
   logic        busy_q;
   logic [3:0]  anode_q;
   logic [6:0]  seg_q;
   logic        dp_n_q;
   logic        frame_done_q;

   logic [3:0]  nibble_d;
   logic [6:0]  seg_dec;
   logic [3:0]  digit_sel;
   logic [3:0]  lead_zero;
   logic        blank_d;
   logic        last_digit;
   logic        commit;

   // div_clock is only ever sampled; its rising edge becomes a one-cycle tick.
   assign scan_tick = s2_q & ~s3_q;

   assign nibble_d = disp_value_q[{digit_idx_q, 2'b00} +: 4];

   hex_to_seg u_dec (
      .nibble_i (nibble_d),
      .seg_o    (seg_dec)
   );

   // lead_zero[k]: digits 3..k are all zero with their decimal points off.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign digit_sel[gi] = (digit_idx_q == 2'(gi));
         assign lead_zero[gi] = (disp_value_q[15:4*gi] == '0) && (disp_dp_q[3:gi] == '0);
      end
   endgenerate

   assign blank_d    = (BLANK_LEADING != 0) && (digit_idx_q != 2'd0) && lead_zero[digit_idx_q];
   assign last_digit = (digit_idx_q == 2'(DIGITS - 1));
   assign commit     = scan_tick && last_digit && busy_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         digit_idx_q  <= 2'd0;
         disp_value_q <= '0;
         disp_dp_q    <= '0;
         pend_value_q <= '0;
         pend_dp_q    <= '0;
         busy_q       <= 1'b0;
         anode_q      <= 4'hF;
         seg_q        <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         s1_q         <= div_clock;
         s2_q         <= s1_q;
         s3_q         <= s2_q;
         frame_done_q <= scan_tick && last_digit;

         if (scan_tick) begin
            anode_q     <= blank_d ? 4'hF : ~digit_sel;
            seg_q       <= blank_d ? SEG_BLANK : seg_dec;
            dp_n_q      <= blank_d | ~disp_dp_q[digit_idx_q];
            digit_idx_q <= digit_idx_q + 2'd1;
         end

         // A load coinciding with the commit still sees the old pending value
         // here, and keeps busy set for the value it just wrote.
         if (commit) begin
            disp_value_q <= pend_value_q;
            disp_dp_q    <= pend_dp_q;
         end
         if (load) begin
            pend_value_q <= value;
            pend_dp_q    <= dp;
         end
         busy_q <= load | (busy_q & ~commit);
      end
   end

   assign busy       = busy_q;
   assign anode      = anode_q;
   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign frame_done = frame_done_q;

endmodule
